// File: rtl/ssd_bcd_scan.sv
// ssd_bcd_scan: 13-bit binary to 4-digit BCD (double dabble)
// with a multiplexed common-anode 7-segment scanner.
module ssd_bcd_scan #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [12:0] value,
  output logic [3:0]  anode,
  output logic [6:0]  cathode,
  output logic [15:0] bcd,
  output logic        busy
);

  localparam int CW =
    (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] RMAX = CW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [12:0]   last_q, last_d;
  logic [12:0]   sh_q, sh_d;
  logic [15:0]   work_q, work_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [15:0]   bcd_q, bcd_d;
  logic          busy_q, busy_d;
  logic [15:0]   adj;

  logic [CW-1:0] refresh_q, refresh_d;
  logic [1:0]    sel_q, sel_d;
  logic          wrap;
  logic [3:0]    nib;
  logic          blank;

  // Converter registers and scan counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      last_q    <= '0;
      sh_q      <= '0;
      work_q    <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      busy_q    <= 1'b0;
      refresh_q <= '0;
      sel_q     <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      sh_q      <= sh_d;
      work_q    <= work_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
      busy_q    <= busy_d;
      refresh_q <= refresh_d;
      sel_q     <= sel_d;
    end
  end

  // Converter next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (value != last_q) state_d = SHIFT;
      SHIFT:   if (cnt_q == 4'd12) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Add-3 correction on every nibble >= 5 before each shift
  always_comb begin
    adj = work_q;
    for (int i = 0; i < 4; i++) begin
      if (work_q[i*4 +: 4] >= 4'd5)
        adj[i*4 +: 4] = work_q[i*4 +: 4] + 4'd3;
    end
  end

  // Converter datapath and outputs
  always_comb begin
    last_d = last_q;
    sh_d   = sh_q;
    work_d = work_q;
    cnt_d  = cnt_q;
    bcd_d  = bcd_q;
    busy_d = busy_q;
    unique case (state_q)
      IDLE: begin
        if (value != last_q) begin
          sh_d   = value;
          work_d = '0;
          cnt_d  = '0;
          last_d = value;
          busy_d = 1'b1;
        end
      end
      SHIFT: begin
        work_d = {adj[14:0], sh_q[12]};
        sh_d   = {sh_q[11:0], 1'b0};
        cnt_d  = cnt_q + 4'd1;
      end
      COMMIT: begin
        bcd_d  = work_q;
        busy_d = 1'b0;
      end
      default: ;
    endcase
  end

  // Refresh divider and digit rotation
  always_comb begin
    wrap      = (refresh_q == RMAX);
    refresh_d = wrap ? '0 : refresh_q + CW'(1);
    sel_d     = wrap ? sel_q + 2'd1 : sel_q;
  end

  // Digit select, leading-zero blanking, segment decode
  always_comb begin
    anode = 4'b1110;
    nib   = bcd_q[3:0];
    blank = 1'b0;
    unique case (sel_q)
      2'd0: begin
        anode = 4'b1110;
        nib   = bcd_q[3:0];
      end
      2'd1: begin
        anode = 4'b1101;
        nib   = bcd_q[7:4];
        blank = (bcd_q[15:4] == '0);
      end
      2'd2: begin
        anode = 4'b1011;
        nib   = bcd_q[11:8];
        blank = (bcd_q[15:8] == '0);
      end
      2'd3: begin
        anode = 4'b0111;
        nib   = bcd_q[15:12];
        blank = (bcd_q[15:12] == '0);
      end
      default: ;
    endcase
    cathode = 7'b1111111;
    if (!blank) begin
      unique case (nib)
        4'd0:    cathode = 7'b1000000;
        4'd1:    cathode = 7'b1111001;
        4'd2:    cathode = 7'b0100100;
        4'd3:    cathode = 7'b0110000;
        4'd4:    cathode = 7'b0011001;
        4'd5:    cathode = 7'b0010010;
        4'd6:    cathode = 7'b0000010;
        4'd7:    cathode = 7'b1111000;
        4'd8:    cathode = 7'b0000000;
        4'd9:    cathode = 7'b0010000;
        default: cathode = 7'b1111111;
      endcase
    end
  end

  assign bcd  = bcd_q;
  assign busy = busy_q;

endmodule
